// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and limits for the programmable clock divider.
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_cfg.sv
// clk_div_cfg: validates LOAD requests, holds the shadow and active period/high-time, flags PEND/ERR.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEF_DIV  = 3,
    parameter int DEF_HIGH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             APPLY,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic [WIDTH-1:0] HIGH_IN,
    output logic [WIDTH-1:0] DIV,
    output logic [WIDTH-1:0] HIGH,
    output logic             PEND,
    output logic             ERR
);
    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] high;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{div: WIDTH'(DEF_DIV), high: WIDTH'(DEF_HIGH)};

    cfg_t shadow, active;
    logic ok, take;

    assign ok   = (DIV_IN >= WIDTH'(MIN_DIV)) && (HIGH_IN != '0) && (HIGH_IN < DIV_IN);
    assign take = LOAD && ok;
    assign DIV  = active.div;
    assign HIGH = active.high;

    // A LOAD coinciding with APPLY moves the older shadow to active and queues the new one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= DEF_CFG;
            active <= DEF_CFG;
            PEND   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            ERR  <= LOAD && !ok;
            PEND <= take || (PEND && !APPLY);
            if (APPLY && PEND)
                active <= shadow;
            if (take)
                shadow <= '{div: DIV_IN, high: HIGH_IN};
        end
    end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider, shadowed config applied on period boundaries, graceful stop.
// Define CLK_DIV_SYNC_EN to add a SYNC input that forces a period boundary while running.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEF_DIV  = 3,
    parameter int DEF_HIGH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic [WIDTH-1:0] HIGH_IN,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             PEND,
    output logic             ERR
`ifdef CLK_DIV_SYNC_EN
    ,
    input  logic             SYNC
`endif
);
    state_t           state, state_d;
    logic [WIDTH-1:0] q, q_d, q_nx, div, high;
    logic             clk_d, tick_d, boundary, apply, sync_hit;

`ifdef CLK_DIV_SYNC_EN
    assign sync_hit = SYNC && (state != IDLE);
`else
    assign sync_hit = 1'b0;
`endif

    clk_div_cfg #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)) u_cfg (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .APPLY(apply),
        .DIV_IN(DIV_IN), .HIGH_IN(HIGH_IN),
        .DIV(div), .HIGH(high), .PEND(PEND), .ERR(ERR)
    );

    always_comb begin
        q_nx     = (sync_hit || q == div - 1'b1) ? '0 : q + 1'b1;
        boundary = (state != IDLE) && (q_nx == '0);
        apply    = (state == IDLE) || boundary;
        state_d  = state;
        q_d      = q_nx;
        clk_d    = q_nx < high;
        tick_d   = boundary;
        case (state)
            IDLE: begin
                state_d = EN ? RUN : IDLE;
                q_d     = '0;
                clk_d   = EN;
                tick_d  = EN;
            end
            RUN: state_d = EN ? RUN : DRAIN;
            DRAIN: begin
                state_d = EN ? RUN : (boundary ? IDLE : DRAIN);
                if (!EN && boundary) begin
                    q_d    = '0;
                    clk_d  = 1'b0;
                    tick_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            q       <= '0;
            CLK_OUT <= 1'b0;
            TICK    <= 1'b0;
        end else begin
            state   <= state_d;
            q       <= q_d;
            CLK_OUT <= clk_d;
            TICK    <= tick_d;
        end
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed-vector bench for clk_div_prog with hand-computed CLK_OUT/TICK/PEND/ERR.
module tb_clk_div_prog;
    logic       CLK = 1'b0;
    logic       RST, EN, LOAD;
    logic [7:0] DIV_IN, HIGH_IN;
    logic       CLK_OUT, TICK, PEND, ERR;
`ifdef CLK_DIV_SYNC_EN
    logic       SYNC;
`endif
    int vectors = 0;
    int miscompares = 0;

    clk_div_prog #(.WIDTH(8), .DEF_DIV(3), .DEF_HIGH(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD),
        .DIV_IN(DIV_IN), .HIGH_IN(HIGH_IN),
        .CLK_OUT(CLK_OUT), .TICK(TICK), .PEND(PEND), .ERR(ERR)
`ifdef CLK_DIV_SYNC_EN
        , .SYNC(SYNC)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_pat(input string tag, input int n, input logic [15:0] clkp, input logic [15:0] tickp);
        for (int i = n - 1; i >= 0; i--) begin
            cyc();
            check(tag, {2'b00, CLK_OUT, TICK}, {2'b00, clkp[i], tickp[i]});
        end
    endtask

    task automatic load(input logic [7:0] d, input logic [7:0] h);
        LOAD = 1'b1;
        DIV_IN = d;
        HIGH_IN = h;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DIV_IN = '0; HIGH_IN = '0;
`ifdef CLK_DIV_SYNC_EN
        SYNC = 1'b0;
`endif
        #2 check("reset", {CLK_OUT, TICK, PEND, ERR}, 4'b0000);
        #10 RST = 1'b0;
        cyc();
        check("idle", {CLK_OUT, TICK, PEND, ERR}, 4'b0000);
        // defaults N=3 H=1
        EN = 1'b1;
        run_pat("def", 6, 16'b100100, 16'b100100);
        check("def_pend", {3'b000, PEND}, 4'b0000);
        run_pat("def7", 1, 16'b1, 16'b1);
        // mid-period load of N=5 H=2
        load(8'd5, 8'd2);
        cyc();
        LOAD = 1'b0;
        check("ld5a", {CLK_OUT, TICK, PEND, ERR}, 4'b0010);
        cyc();
        check("ld5b", {CLK_OUT, TICK, PEND, ERR}, 4'b0010);
        run_pat("n5a", 1, 16'b1, 16'b1);
        check("pend_clr", {3'b000, PEND}, 4'b0000);
        run_pat("n5b", 5, 16'b10001, 16'b00001);
        // rejected loads
        load(8'd4, 8'd4);
        cyc();
        check("err_hi", {CLK_OUT, TICK, PEND, ERR}, 4'b1001);
        load(8'd1, 8'd0);
        cyc();
        check("err_div", {CLK_OUT, TICK, PEND, ERR}, 4'b0001);
        LOAD = 1'b0;
        cyc();
        check("err_clr", {CLK_OUT, TICK, PEND, ERR}, 4'b0000);
        run_pat("n5c", 2, 16'b01, 16'b01);
        // N=6 H=3, graceful drain, resume from drain
        load(8'd6, 8'd3);
        run_pat("ld6a", 1, 16'b1, 16'b0);
        LOAD = 1'b0;
        check("ld6_pend", {3'b000, PEND}, 4'b0001);
        run_pat("ld6b", 4, 16'b0001, 16'b0001);
        check("ld6_clr", {3'b000, PEND}, 4'b0000);
        run_pat("q1", 1, 16'b1, 16'b0);
        EN = 1'b0;
        run_pat("drain", 6, 16'b100000, 16'b000000);
        EN = 1'b1;
        run_pat("start", 3, 16'b111, 16'b100);
        EN = 1'b0;
        run_pat("dr2", 1, 16'b0, 16'b0);
        EN = 1'b1;
        run_pat("resume", 6, 16'b001110, 16'b001000);
        // load on boundary, then async reset mid-high with PEND set
        run_pat("pre_bnd", 2, 16'b00, 16'b00);
        load(8'd7, 8'd2);
        run_pat("bnd", 1, 16'b1, 16'b1);
        LOAD = 1'b0;
        check("bnd_pend", {3'b000, PEND}, 4'b0001);
        #2 RST = 1'b1;
        #1 check("async_rst", {CLK_OUT, TICK, PEND, ERR}, 4'b0000);
        #3 RST = 1'b0;
        run_pat("rst_def", 4, 16'b1001, 16'b1001);
        check("rst_pend", {3'b000, PEND}, 4'b0000);
        // overwrite while pending: only the latest applies
        load(8'd5, 8'd2);
        run_pat("ow1", 1, 16'b0, 16'b0);
        load(8'd4, 8'd2);
        run_pat("ow2", 1, 16'b0, 16'b0);
        LOAD = 1'b0;
        check("ow_pend", {3'b000, PEND}, 4'b0001);
        run_pat("ow3", 5, 16'b11001, 16'b10001);
        check("ow_clr", {3'b000, PEND}, 4'b0000);
        // stop, then load minimum legal config in IDLE
        EN = 1'b0;
        run_pat("dr3", 4, 16'b1000, 16'b0000);
        load(8'd2, 8'd1);
        cyc();
        LOAD = 1'b0;
        check("idle_ld", {CLK_OUT, TICK, PEND, ERR}, 4'b0010);
        cyc();
        check("idle_ap", {CLK_OUT, TICK, PEND, ERR}, 4'b0000);
        EN = 1'b1;
        run_pat("n2", 4, 16'b1010, 16'b1010);
`ifdef CLK_DIV_SYNC_EN
        load(8'd8, 8'd4);
        run_pat("s_ld", 1, 16'b1, 16'b1);
        LOAD = 1'b0;
        run_pat("s_ap", 2, 16'b01, 16'b01);
        run_pat("s_a", 1, 16'b1, 16'b0);
        load(8'd10, 8'd5);
        run_pat("s_b", 1, 16'b1, 16'b0);
        LOAD = 1'b0;
        run_pat("s_c", 3, 16'b100, 16'b000);
        check("s_pend", {3'b000, PEND}, 4'b0001);
        SYNC = 1'b1;
        run_pat("sync", 1, 16'b1, 16'b1);
        SYNC = 1'b0;
        check("s_clr", {3'b000, PEND}, 4'b0000);
        run_pat("n10", 10, 16'b1111000001, 16'b0000000001);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable, parametrised successor to the fixed divide-by-3 clock divider in the BLDC controller.
- Produces a registered, glitch-free divided clock enable/clock CLK_OUT with programmable period and high time, plus a one-cycle TICK at each period start.
- Divisor/high-time updates are shadowed and applied only on period boundaries.
- Start/stop is graceful, so PWM/commutation timing never sees a truncated pulse.

Parameters:
- WIDTH, 8, width of period/high-time fields and internal counter.
- DEF_DIV, 3, period N (CLK cycles) after reset; legal range 2..2^WIDTH-1.
- DEF_HIGH, 1, high time H (CLK cycles) after reset; legal range 1..DEF_DIV-1.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run request.
- LOAD  in  1  one-cycle strobe; captures DIV_IN/HIGH_IN.
- DIV_IN  in  WIDTH  requested period N.
- HIGH_IN  in  WIDTH  requested high time H.
- CLK_OUT  out  1  divided output, registered.
- TICK  out  1  one-cycle pulse, first cycle of each period.
- PEND  out  1  validated config waiting for boundary.
- ERR  out  1  one-cycle pulse: LOAD rejected.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, Q=0.
  - active N/H = DEF_DIV/DEF_HIGH, shadow = defaults.
  - CLK_OUT=0, TICK=0, PEND=0, ERR=0.
  - Reset mid-period drops outputs immediately; any pending config is discarded.
- States IDLE, RUN, DRAIN; Q is an unsigned WIDTH-bit counter.
- IDLE:
  - Q=0, CLK_OUT=0, TICK=0.
  - EN=1 at an edge → RUN; same edge: apply pending config, Q<=0, CLK_OUT<=1, TICK<=1.
- RUN/DRAIN advance:
  - Q_next = (Q==N-1) ? 0 : Q+1.
  - CLK_OUT <= (Q_next < H); TICK <= (Q_next==0).
  - Boundary = edge where Q_next==0.
  - Result: CLK_OUT is high for exactly H cycles, low for N-H cycles.
  - Example, N=3, H=1: CLK_OUT pattern 1,0,0, repeating; TICK coincident with each high cycle.
- RUN with EN=0 → DRAIN. DRAIN keeps counting to the end of the current period.
- DRAIN exits:
  - At the boundary with EN=0 → IDLE; outputs 0, no partial high pulse.
  - EN=1 in DRAIN → RUN immediately, counting undisturbed.
- LOAD validation: accepted iff 2 <= DIV_IN and 1 <= HIGH_IN < DIV_IN.
  - Accepted: shadow <= inputs, PEND <= 1.
  - Rejected: ERR <= 1 for one cycle; shadow and PEND unchanged.
- Apply rules:
  - Pending config applies at the next boundary: N/H take effect for the period starting at that edge, and PEND clears there.
  - In IDLE, an accepted LOAD applies at the next edge; PEND is high for one cycle.
- LOAD while PEND=1: newer value overwrites shadow; only the latest is applied.
- LOAD on the same edge as a boundary: the previously pending config applies; the new value becomes pending for the following boundary.
- All comparisons are unsigned WIDTH-bit; Q never exceeds N-1, so no overflow.

Optional Feature:
CLK_DIV_SYNC_EN
- Defined: adds port SYNC (in, 1).
  - SYNC=1 in RUN or DRAIN forces a boundary on that edge: Q<=0, CLK_OUT<=1, TICK<=1, pending config applied.
  - Used to phase-align the divider to a hall-sensor edge.
  - SYNC in IDLE is ignored.
  - SYNC together with a DRAIN-ending boundary behaves as a boundary with EN=0, i.e. → IDLE.
- Undefined: no SYNC port; boundaries occur only by counter wrap.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - constant MIN_DIV=2;
  - config struct {div, high} parametrised by WIDTH via localparam in the module.
- One natural sub-module: clk_div_cfg. It holds LOAD validation, the shadow register, PEND and ERR, and presents the active config plus an apply strobe.

Test Plan:
1. Reset, EN=1, defaults (N=3, H=1) → CLK_OUT 1,0,0 repeating from the first enabled edge; TICK on every CLK_OUT high cycle; PEND=0.
2. Running at N=3: LOAD DIV_IN=5, HIGH_IN=2 mid-period → PEND=1 until the next boundary; then CLK_OUT 1,1,0,0,0 repeating; no period of length other than 3 or 5.
3. LOAD DIV_IN=4, HIGH_IN=4, then DIV_IN=1, HIGH_IN=0 → ERR one-cycle pulse each time; PEND stays 0; output pattern unchanged.
4. N=6, H=3, EN dropped at Q=1 → current period completes (3 high, 3 low); IDLE after the boundary. EN reasserted during DRAIN → continuous pattern, no gap.
5. RST asserted asynchronously while CLK_OUT=1 with PEND=1 → CLK_OUT, TICK, PEND fall without waiting for CLK; after release, N=3, H=1 restored.
6. (CLK_DIV_SYNC_EN) N=8, H=4, SYNC at Q=5 → next cycle Q=0, CLK_OUT=1, TICK=1; pending LOAD of N=10, H=5 applied at that SYNC.
